// File: rtl/uart_buf_pkg.sv
// uart_buf_pkg
//   Shared types and defaults for the UART buffer controller:
//   RX/TX state encodings and default character / overrun counter widths.
//   Used by uart_buf_ctrl (top) and uart_buf_tx_fsm.
package uart_buf_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OVR_W_DEF  = 8;

  typedef enum logic [2:0] {
    RX_CLR,
    RX_WAIT_LOW,
    RX_WAIT_RDY,
    RX_OFFER,
    RX_HOLD
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_POP,
    TX_LOAD,
    TX_WAIT_BUSY
  } tx_state_t;

endpackage

// File: rtl/uart_buf_tx_fsm.sv
// uart_buf_tx_fsm
//   Moves characters from the tx buffer into the UART transmitter holding
//   register: pop one word, present it, strobe the transmitter, then wait
//   for the transmitter to go busy before looking at the buffer again.
//
//   state        | meaning
//   -------------+-----------------------------------------------
//   TX_IDLE      | wait for a buffered word and an empty THR
//   TX_POP       | tx_pop=1, head word captured into tx_out
//   TX_LOAD      | wrn=1, transmitter loads tx_out
//   TX_WAIT_BUSY | wait for tbre=0 so the same slot is not reused
//
// Ports
//   genclk, rst          clock, async active-high reset
//   tx_empty, tx_data    tx buffer status and head word
//   tbre                 transmitter holding register empty
//   tx_pop               one-cycle pop strobe to the tx buffer
//   wrn                  one-cycle load strobe to the transmitter
//   tx_out               character presented to the transmitter
module uart_buf_tx_fsm
  import uart_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              genclk,
  input  logic              rst,
  input  logic              tx_empty,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tbre,
  output logic              tx_pop,
  output logic              wrn,
  output logic [DATA_W-1:0] tx_out
);

  tx_state_t tx_state;
  tx_state_t tx_next;

  always_ff @(posedge genclk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:      if (!tx_empty && tbre) tx_next = TX_POP;
      TX_POP:       tx_next = TX_LOAD;
      TX_LOAD:      tx_next = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (!tbre) tx_next = TX_IDLE;
      default:      tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = 1'b0;
    wrn    = 1'b0;
    case (tx_state)
      TX_POP:  tx_pop = 1'b1;
      TX_LOAD: wrn    = 1'b1;
      default: ;
    endcase
  end

  // Captured on the pop edge and held until the next pop.
  always_ff @(posedge genclk or posedge rst) begin
    if (rst) begin
      tx_out <= '0;
    end else if (tx_state == TX_POP) begin
      tx_out <= tx_data;
    end
  end

endmodule

// File: rtl/uart_buf_ctrl.sv
// uart_buf_ctrl
//   Glue between a UART (receiver/transmitter holding registers) and a pair
//   of rx/tx buffers. The RX state machine and overrun tracking live here;
//   the TX path is uart_buf_tx_fsm. Both paths run independently.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   RX_CLR      | rdrst=1 for one cycle, clears the receiver
//   RX_WAIT_LOW | wait for rdrdy to drop after the clear
//   RX_WAIT_RDY | wait for a character, capture rbr into rx_buf
//   RX_OFFER    | offer rx_buf to the rx buffer until rx_ack
//   RX_HOLD     | rx buffer full; newer characters overwrite rx_buf
//
// Ports
//   genclk, rst                   clock, async active-high reset
//   rbr, rdrdy, rdrst             receiver data, ready level, clear pulse
//   rx_rfd, rx_full, rx_ack       rx buffer handshake inputs
//   newdata, rx_buf               word offered to the rx buffer
//   tx_empty, tx_data, tx_pop     tx buffer side
//   tbre, wrn, tx_out             transmitter side
//   overrun                       sticky lost-character flag
//   ovr_cnt                       saturating lost-character count, only
//                                 when UART_BUF_OVRCNT_EN is defined
module uart_buf_ctrl
  import uart_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OVR_W  = OVR_W_DEF
) (
  input  logic              genclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rbr,
  input  logic              rdrdy,
  output logic              rdrst,
  input  logic              rx_rfd,
  input  logic              rx_full,
  input  logic              rx_ack,
  output logic              newdata,
  output logic [DATA_W-1:0] rx_buf,
  input  logic              tx_empty,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_pop,
  input  logic              tbre,
  output logic              wrn,
  output logic [DATA_W-1:0] tx_out,
`ifdef UART_BUF_OVRCNT_EN
  output logic [OVR_W-1:0]  ovr_cnt,
`endif
  output logic              overrun
);

  if (OVR_W < 1) begin : g_bad_ovr_w
    $error("OVR_W must be at least 1");
  end

  rx_state_t rx_state;
  rx_state_t rx_next;
  logic      rdrdy_q;
  logic      load_rbr;
  logic      newdata_nxt;
  logic      ovr_evt;

  // A fresh character while parked in HOLD replaces the one waiting.
  assign ovr_evt = (rx_state == RX_HOLD) && rdrdy && !rdrdy_q;

  always_ff @(posedge genclk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_CLR;
    end else begin
      rx_state <= rx_next;
    end
  end

  // rx_ack wins over rx_full in OFFER: an accepted word must not be re-offered.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_CLR:      rx_next = RX_WAIT_LOW;
      RX_WAIT_LOW: if (!rdrdy) rx_next = RX_WAIT_RDY;
      RX_WAIT_RDY: if (rdrdy) rx_next = rx_full ? RX_HOLD : RX_OFFER;
      RX_OFFER: begin
        if (rx_ack)       rx_next = RX_CLR;
        else if (rx_full) rx_next = RX_HOLD;
      end
      RX_HOLD:     if (!rx_full) rx_next = RX_OFFER;
      default:     rx_next = RX_CLR;
    endcase
  end

  // rdrst is gated by rst so the clear pulse lands in the first cycle
  // after reset release rather than during reset.
  always_comb begin
    rdrst       = 1'b0;
    load_rbr    = 1'b0;
    newdata_nxt = 1'b0;
    case (rx_state)
      RX_CLR:      rdrst       = !rst;
      RX_WAIT_RDY: load_rbr    = rdrdy;
      RX_OFFER:    newdata_nxt = rx_rfd && !rx_full && !rx_ack;
      RX_HOLD:     load_rbr    = ovr_evt;
      default: ;
    endcase
  end

  always_ff @(posedge genclk or posedge rst) begin
    if (rst) begin
      rdrdy_q <= 1'b0;
      newdata <= 1'b0;
      rx_buf  <= '0;
      overrun <= 1'b0;
    end else begin
      rdrdy_q <= rdrdy;
      newdata <= newdata_nxt;
      if (load_rbr) rx_buf  <= rbr;
      if (ovr_evt)  overrun <= 1'b1;
    end
  end

`ifdef UART_BUF_OVRCNT_EN
  always_ff @(posedge genclk or posedge rst) begin
    if (rst) begin
      ovr_cnt <= '0;
    end else if (ovr_evt && (ovr_cnt != {OVR_W{1'b1}})) begin
      ovr_cnt <= ovr_cnt + OVR_W'(1);
    end
  end
`endif

  uart_buf_tx_fsm #(
    .DATA_W(DATA_W)
  ) u_tx_fsm (
    .genclk   (genclk),
    .rst      (rst),
    .tx_empty (tx_empty),
    .tx_data  (tx_data),
    .tbre     (tbre),
    .tx_pop   (tx_pop),
    .wrn      (wrn),
    .tx_out   (tx_out)
  );

endmodule

// File: tb/tb_uart_buf_ctrl.sv
// tb_uart_buf_ctrl
//   Scoreboard bench for uart_buf_ctrl. Expected rx words and tx characters
//   are queued when stimulus is issued; a monitor pops and compares them
//   whenever the DUT completes an rx handshake or strobes wrn. A small tx
//   buffer / transmitter model feeds the TX path. Build with
//   UART_BUF_OVRCNT_EN defined to also exercise ovr_cnt.
module tb_uart_buf_ctrl;

  logic       genclk;
  logic       rst;
  logic [7:0] rbr;
  logic       rdrdy;
  logic       rdrst;
  logic       rx_rfd;
  logic       rx_full;
  logic       rx_ack;
  logic       newdata;
  logic [7:0] rx_buf;
  logic       tx_empty;
  logic [7:0] tx_data;
  logic       tx_pop;
  logic       tbre;
  logic       wrn;
  logic [7:0] tx_out;
  logic       overrun;
`ifdef UART_BUF_OVRCNT_EN
  logic [7:0] ovr_cnt;
  localparam int N_OVR = 299;
`else
  localparam int N_OVR = 3;
`endif

  int checks = 0;
  int errors = 0;
  int wrn_cnt = 0;
  int pop_cnt = 0;
  int rdrst_cnt = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_q[$];

  uart_buf_ctrl dut (
    .genclk   (genclk),
    .rst      (rst),
    .rbr      (rbr),
    .rdrdy    (rdrdy),
    .rdrst    (rdrst),
    .rx_rfd   (rx_rfd),
    .rx_full  (rx_full),
    .rx_ack   (rx_ack),
    .newdata  (newdata),
    .rx_buf   (rx_buf),
    .tx_empty (tx_empty),
    .tx_data  (tx_data),
    .tx_pop   (tx_pop),
    .tbre     (tbre),
    .wrn      (wrn),
    .tx_out   (tx_out),
`ifdef UART_BUF_OVRCNT_EN
    .ovr_cnt  (ovr_cnt),
`endif
    .overrun  (overrun)
  );

  initial genclk = 1'b0;
  always #5 genclk = ~genclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge.
  initial begin : monitor
    logic       prev_pop;
    logic       prev_rdrst;
    logic [7:0] e;
    prev_pop   = 1'b0;
    prev_rdrst = 1'b0;
    forever begin
      @(negedge genclk);
      #1;
      if (tx_pop) begin
        pop_cnt++;
        chk("single_pop", {31'd0, prev_pop}, 0);
      end
      if (wrn) begin
        wrn_cnt++;
        chk("pop_to_wrn", {31'd0, prev_pop}, 1);
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL wrn_unexpected: actual tx_out=%0h required no wrn", tx_out);
        end else begin
          e = exp_tx.pop_front();
          checks--;
          chk("tx_out", {24'd0, tx_out}, {24'd0, e});
        end
      end
      if (newdata && rx_ack) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: actual rx_buf=%0h required no offer", rx_buf);
        end else begin
          e = exp_rx.pop_front();
          checks--;
          chk("rx_buf_word", {24'd0, rx_buf}, {24'd0, e});
        end
      end
      if (rdrst) begin
        rdrst_cnt++;
        chk("rdrst_width", {31'd0, prev_rdrst}, 0);
      end
      prev_pop   = tx_pop;
      prev_rdrst = rdrst;
    end
  end

  // tx buffer and transmitter model: runs after the monitor each cycle.
  initial begin : tx_env
    logic pop_pending;
    int   busy;
    pop_pending = 1'b0;
    busy        = 0;
    tbre        = 1'b1;
    tx_empty    = 1'b1;
    tx_data     = 8'h00;
    forever begin
      @(negedge genclk);
      #2;
      if (pop_pending && tx_q.size() != 0) void'(tx_q.pop_front());
      pop_pending = tx_pop;
      if (wrn) begin
        tbre = 1'b0;
        busy = 3;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) tbre = 1'b1;
      end
      tx_empty = (tx_q.size() == 0);
      tx_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    end
  end

  initial begin : watchdog
    #60000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge genclk);
  endtask

  task automatic wait_newdata(input string name);
    int n = 0;
    while (!newdata && n < 50) begin
      @(negedge genclk);
      n++;
    end
    chk(name, {31'd0, newdata}, 1);
  endtask

  task automatic ack_rx();
    rx_ack = 1'b1;
    @(negedge genclk);
    rx_ack = 1'b0;
    chk("ack_newdata_drop", {31'd0, newdata}, 0);
    chk("ack_rdrst", {31'd0, rdrst}, 1);
    rdrdy = 1'b0;
    @(negedge genclk);
    chk("ack_rdrst_end", {31'd0, rdrst}, 0);
    tick(2);
  endtask

  task automatic wait_tx_done();
    int n = 0;
    while (exp_tx.size() != 0 && n < 100) begin
      @(negedge genclk);
      n++;
    end
    chk("tx_drained", exp_tx.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_newdata"}, {31'd0, newdata}, 0);
    chk({tag, "_rdrst"},   {31'd0, rdrst},   0);
    chk({tag, "_tx_pop"},  {31'd0, tx_pop},  0);
    chk({tag, "_wrn"},     {31'd0, wrn},     0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 0);
    chk({tag, "_rx_buf"},  {24'd0, rx_buf},  0);
    chk({tag, "_tx_out"},  {24'd0, tx_out},  0);
`ifdef UART_BUF_OVRCNT_EN
    chk({tag, "_ovr_cnt"}, {24'd0, ovr_cnt}, 0);
`endif
  endtask

  initial begin : main
    int         wc0;
    int         pc0;
    int         rc0;
    logic [7:0] last;
    rst     = 1'b1;
    rbr     = 8'h00;
    rdrdy   = 1'b0;
    rx_rfd  = 1'b1;
    rx_full = 1'b0;
    rx_ack  = 1'b0;
    tick(3);
    chk_all_zero("reset");

    rst = 1'b0;
    #1;
    chk("rdrst_after_release", {31'd0, rdrst}, 1);
    @(negedge genclk);
    chk("rdrst_one_cycle", {31'd0, rdrst}, 0);
    tick(2);

    // Single receive with latency checks
    rbr = 8'hA5; rdrdy = 1'b1; exp_rx.push_back(8'hA5);
    @(negedge genclk);
    chk("rx_buf_latency", {24'd0, rx_buf}, 32'hA5);
    chk("newdata_not_early", {31'd0, newdata}, 0);
    @(negedge genclk);
    chk("newdata_two_cycles", {31'd0, newdata}, 1);
    ack_rx();

    // Full hold
    rx_full = 1'b1; rbr = 8'h3C; rdrdy = 1'b1; exp_rx.push_back(8'h3C);
    repeat (3) begin
      @(negedge genclk);
      chk("hold_newdata", {31'd0, newdata}, 0);
    end
    chk("hold_rx_buf", {24'd0, rx_buf}, 32'h3C);
    rx_full = 1'b0;
    @(negedge genclk);
    chk("hold_release_wait", {31'd0, newdata}, 0);
    @(negedge genclk);
    chk("hold_release_newdata", {31'd0, newdata}, 1);
    ack_rx();

    // Overrun in HOLD
    rx_full = 1'b1; rbr = 8'h55; rdrdy = 1'b1;
    @(negedge genclk);
    chk("ovr_before", {31'd0, overrun}, 0);
    rdrdy = 1'b0;
    @(negedge genclk);
    rbr = 8'h77; rdrdy = 1'b1;
    @(negedge genclk);
    chk("ovr_rx_buf", {24'd0, rx_buf}, 32'h77);
    chk("ovr_flag", {31'd0, overrun}, 1);
`ifdef UART_BUF_OVRCNT_EN
    chk("ovr_cnt_one", {24'd0, ovr_cnt}, 1);
`endif
    last = 8'h77;
    for (int i = 0; i < N_OVR; i++) begin
      rdrdy = 1'b0;
      @(negedge genclk);
      last = 8'(i + 8'h80);
      rbr = last; rdrdy = 1'b1;
      @(negedge genclk);
    end
`ifdef UART_BUF_OVRCNT_EN
    chk("ovr_cnt_sat", {24'd0, ovr_cnt}, 255);
`endif
    chk("ovr_newest_kept", {24'd0, rx_buf}, {24'd0, last});
    exp_rx.push_back(last);
    rx_full = 1'b0;
    wait_newdata("ovr_release_newdata");
    ack_rx();
    chk("ovr_sticky", {31'd0, overrun}, 1);

    // TX drain
    pc0 = pop_cnt; wc0 = wrn_cnt;
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
    wait_tx_done();
    tick(6);
    chk("tx_pop_count", pop_cnt - pc0, 3);
    chk("tx_wrn_count", wrn_cnt - wc0, 3);
    chk("tx_out_hold", {24'd0, tx_out}, 32'h33);

    // Concurrent RX offer and TX pop
    rbr = 8'h99; rdrdy = 1'b1; exp_rx.push_back(8'h99);
    tx_q.push_back(8'h44); exp_tx.push_back(8'h44);
    @(negedge genclk);
    chk("conc_tx_pop", {31'd0, tx_pop}, 1);
    chk("conc_rx_buf", {24'd0, rx_buf}, 32'h99);
    @(negedge genclk);
    chk("conc_newdata", {31'd0, newdata}, 1);
    ack_rx();
    wait_tx_done();
    tick(6);

    // Reset in OFFER and LOAD
    rbr = 8'h5A; rdrdy = 1'b1;
    tx_q.push_back(8'h66);
    @(negedge genclk);
    chk("mid_tx_pop", {31'd0, tx_pop}, 1);
    @(negedge genclk);
    chk("mid_newdata", {31'd0, newdata}, 1);
    chk("mid_wrn", {31'd0, wrn}, 1);
    wc0 = wrn_cnt; rc0 = rdrst_cnt;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    repeat (3) begin
      @(negedge genclk);
      chk("in_reset_wrn", {31'd0, wrn}, 0);
    end
    rst = 1'b0;
    #1;
    chk("mid_rdrst_release", {31'd0, rdrst}, 1);
    rdrdy = 1'b0;
    tick(10);
    chk("mid_no_wrn", wrn_cnt - wc0, 0);
    chk("mid_rdrst_pulses", rdrst_cnt - rc0, 1);
    chk("mid_no_newdata", {31'd0, newdata}, 0);

    // Normal operation after reset
    rbr = 8'hC3; rdrdy = 1'b1; exp_rx.push_back(8'hC3);
    wait_newdata("post_reset_newdata");
    ack_rx();
    chk("rx_sb_empty", exp_rx.size(), 0);
    chk("tx_sb_empty", exp_tx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_buf_ctrl.md
UART_BUF_CTRL -- requirements
Module: uart_buf_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of the UART character and the buffer word.
REQ-002 Parameter OVR_W, default 8: width of the overrun counter.
REQ-003 genclk  in  1  sole clock; all state is updated on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rbr  in  DATA_W  receiver holding register.
REQ-006 rdrdy  in  1  level; high while the receiver holds a character.
REQ-007 rdrst  out  1  one-cycle pulse that clears the receiver.
REQ-008 rx_rfd  in  1  rx buffer is ready for data.
REQ-009 rx_full  in  1  rx buffer is full.
REQ-010 rx_ack  in  1  rx buffer has accepted the offered word.
REQ-011 newdata  out  1  rx_buf holds a valid word offered to the rx buffer.
REQ-012 rx_buf  out  DATA_W  word offered to the rx buffer.
REQ-013 tx_empty  in  1  tx buffer is empty.
REQ-014 tx_data  in  DATA_W  head word of the tx buffer; valid while tx_empty=0.
REQ-015 tx_pop  out  1  one-cycle pulse that removes the head word.
REQ-016 tbre  in  1  transmitter holding register is empty.
REQ-017 wrn  out  1  one-cycle load strobe to the transmitter.
REQ-018 tx_out  out  DATA_W  character presented to the transmitter.
REQ-019 overrun  out  1  sticky flag: a received character was lost.
REQ-020 ovr_cnt  out  OVR_W  lost-character count; present only with the configuration macro defined.

Function
REQ-021 The RX and TX state machines shall run independently; both may be active in the same cycle.
REQ-022 RX states: CLR, WAIT_LOW, WAIT_RDY, OFFER, HOLD.
- CLR: rdrst=1 for exactly one cycle, then go to WAIT_LOW.
- WAIT_LOW: go to WAIT_RDY when rdrdy=0.
- WAIT_RDY: when rdrdy=1, register rbr into rx_buf; then go to OFFER if rx_full=0, else go to HOLD.
REQ-023 OFFER: newdata=1 while rx_rfd=1 and rx_full=0; hold rx_buf stable until rx_ack; on rx_ack, drive newdata=0 the next cycle and go to CLR.
REQ-024 Latency: rdrdy rising sampled at edge N -> rx_buf valid after edge N; newdata=1 after edge N+1 at the earliest.
REQ-025 HOLD: newdata=0; go to OFFER when rx_full=0.
REQ-026 Overrun in HOLD: a 0->1 transition of rdrdy shall replace rx_buf with rbr and set overrun; the newest character is kept.
REQ-027 rx_full rising while in OFFER shall drop newdata and go to HOLD; rx_buf is retained.
REQ-028 rx_ack outside OFFER shall be ignored.
REQ-029 TX states: IDLE, POP, LOAD, WAIT_BUSY.
- IDLE: go to POP when tx_empty=0 and tbre=1.
- POP: tx_pop=1 and tx_out<=tx_data.
- LOAD: wrn=1.
- WAIT_BUSY: go to IDLE when tbre=0.
REQ-030 At most one tx_pop shall be issued per character; the pop-to-wrn latency is one cycle.
REQ-031 tx_out shall hold its value until the next POP.
REQ-032 overrun shall clear only on reset.

Reset
REQ-033 On rst: RX state is CLR, TX state is IDLE; newdata, rdrst, tx_pop, wrn and overrun are 0; rx_buf, tx_out and ovr_cnt are all-zero.
REQ-034 A reset asserted mid-transaction shall abandon the transaction; the held character is discarded and no tx_pop or wrn is issued.
REQ-035 After rst deasserts, the first cycle shall pulse rdrst.

Configuration
REQ-036 With UART_BUF_OVRCNT_EN defined, ovr_cnt shall increment on every overrun event and saturate at 2^OVR_W-1.
REQ-037 With UART_BUF_OVRCNT_EN undefined, the ovr_cnt port and its counter are absent; the overrun flag is unchanged.

Structure
REQ-038 Package uart_buf_pkg shall hold the rx_state_t and tx_state_t enums and the default DATA_W and OVR_W constants.
REQ-039 The TX state machine shall be sub-module uart_buf_tx_fsm; the RX state machine and the overrun logic stay in the top level.

Verification
REQ-040 Single receive: rbr=8'hA5, rdrdy rises, rx_rfd=1 -> rx_buf=A5 and newdata=1 two cycles later; rx_ack -> newdata=0 and one rdrst pulse.
REQ-041 Full hold: rx_full=1 when rdrdy rises with 8'h3C -> newdata stays 0; rx_full falls -> newdata=1 with rx_buf=3C.
REQ-042 Overrun: in HOLD, rdrdy toggles with 8'h77 -> rx_buf=77, overrun=1, ovr_cnt=1; 300 events -> ovr_cnt=255.
REQ-043 TX drain: tx buffer holds 8'h11, 8'h22, 8'h33, and tbre toggles -> three tx_pop pulses, each followed one cycle later by wrn, with tx_out 11, 22, 33 in order.
REQ-044 Concurrency: an RX offer and a TX pop in the same cycle -> both complete with no lost word.
REQ-045 Reset mid-operation: rst asserted in OFFER and LOAD -> all outputs 0 within the reset, no wrn, and rdrst pulses after release.
